andor_sweep_checker: RTL and testbench

//  Upstream stimulus/downstream check stage for the two-section AND-OR gate block
//  (p1y = abc|def, p2y = ab|cd). Sweeps all 1024 input combinations into the gate,

---
 rtl/andor_chk_pkg.sv | 29 ++
 rtl/andor_golden.sv | 17 +
 rtl/andor_sweep_checker.sv | 179 +++++++++++++++++
 tb/tb_andor_sweep_checker.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/andor_chk_pkg.sv
// Shared constants for the AND-OR gate sweep checker: FSM state codes,
// vector width and the mapping of vector bits onto the gate input pins.
package andor_chk_pkg;

    localparam int VEC_W = 10;

    typedef logic [VEC_W-1:0] vec_t;

    localparam vec_t VEC_LAST = 10'd1023;

    // Section-2 pins occupy the low nibble, section-1 pins the upper six bits
    localparam int P2A_BIT = 0;
    localparam int P2B_BIT = 1;
    localparam int P2C_BIT = 2;
    localparam int P2D_BIT = 3;
    localparam int P1A_BIT = 4;
    localparam int P1B_BIT = 5;
    localparam int P1C_BIT = 6;
    localparam int P1D_BIT = 7;
    localparam int P1E_BIT = 8;
    localparam int P1F_BIT = 9;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/andor_golden.sv
// Combinational reference for the two-section AND-OR gate:
// p1y = abc | def on vec[9:4], p2y = ab | cd on vec[3:0].
module andor_golden
    import andor_chk_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             p1y_exp,
    output logic             p2y_exp
);

    assign p1y_exp = (vec[P1A_BIT] & vec[P1B_BIT] & vec[P1C_BIT]) |
                     (vec[P1D_BIT] & vec[P1E_BIT] & vec[P1F_BIT]);

    assign p2y_exp = (vec[P2A_BIT] & vec[P2B_BIT]) |
                     (vec[P2C_BIT] & vec[P2D_BIT]);

endmodule

// File: rtl/andor_sweep_checker.sv
// Exhaustive self-test sweep for the AND-OR gate block: drives all 1024 vectors,
// samples the gate after a settle window and accumulates mismatch results.
// Build option STOP_ON_ERR_EN: halt on the first mismatch with the failing vector held.
module andor_sweep_checker
    import andor_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ERR_CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 p1a,
    output logic                 p1b,
    output logic                 p1c,
    output logic                 p1d,
    output logic                 p1e,
    output logic                 p1f,
    output logic                 p2a,
    output logic                 p2b,
    output logic                 p2c,
    output logic                 p2d,
    input  logic                 p1y_i,
    input  logic                 p2y_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [VEC_W-1:0]     first_err_vec,
    output logic                 first_err_vld
);

    localparam logic [3:0]           SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE     = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

    logic [2:0]           state_r, state_s;
    logic [VEC_W-1:0]     vec_r, vec_s;
    logic [3:0]           cnt_r, cnt_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 pass_r, pass_s;
    logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic [VEC_W-1:0]     fev_r, fev_s;
    logic                 fvld_r, fvld_s;
    logic                 finish_s;
    logic                 p1y_exp_s, p2y_exp_s;
    logic                 mismatch_s;

    andor_golden u_golden (
        .vec     (vec_r),
        .p1y_exp (p1y_exp_s),
        .p2y_exp (p2y_exp_s)
    );

    assign mismatch_s = ({p1y_i, p2y_i} != {p1y_exp_s, p2y_exp_s});

    // Next-state and result update logic for the sweep FSM
    always_comb begin
        state_s   = state_r;
        vec_s     = vec_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        pass_s    = pass_r;
        err_cnt_s = err_cnt_r;
        fev_s     = fev_r;
        fvld_s    = fvld_r;
        finish_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s   = ST_DRIVE;
                    vec_s     = {VEC_W{1'b0}};
                    busy_s    = 1'b1;
                    pass_s    = 1'b0;
                    err_cnt_s = {ERR_CNT_W{1'b0}};
                    fev_s     = {VEC_W{1'b0}};
                    fvld_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                cnt_s   = SETTLE_LOAD;
                state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_CHECK;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (err_cnt_r != ERR_MAX) begin
                        err_cnt_s = err_cnt_r + ERR_ONE;
                    end else begin
                        err_cnt_s = ERR_MAX;
                    end
                    if (!fvld_r) begin
                        fev_s  = vec_r;
                        fvld_s = 1'b1;
                    end else begin
                        fev_s = fev_r;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
`ifdef STOP_ON_ERR_EN
                finish_s = (vec_r == VEC_LAST) || mismatch_s;
`else
                finish_s = (vec_r == VEC_LAST);
`endif
                // pass reflects the result including the compare made in this cycle
                if (finish_s) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = !fvld_s;
                end else begin
                    state_s = ST_DRIVE;
                    vec_s   = vec_r + 10'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep in progress
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            vec_r     <= {VEC_W{1'b0}};
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_cnt_r <= {ERR_CNT_W{1'b0}};
            fev_r     <= {VEC_W{1'b0}};
            fvld_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            vec_r     <= vec_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            err_cnt_r <= err_cnt_s;
            fev_r     <= fev_s;
            fvld_r    <= fvld_s;
        end
    end

    assign p1a           = vec_r[P1A_BIT];
    assign p1b           = vec_r[P1B_BIT];
    assign p1c           = vec_r[P1C_BIT];
    assign p1d           = vec_r[P1D_BIT];
    assign p1e           = vec_r[P1E_BIT];
    assign p1f           = vec_r[P1F_BIT];
    assign p2a           = vec_r[P2A_BIT];
    assign p2b           = vec_r[P2B_BIT];
    assign p2c           = vec_r[P2C_BIT];
    assign p2d           = vec_r[P2D_BIT];
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_cnt       = err_cnt_r;
    assign first_err_vec = fev_r;
    assign first_err_vld = fvld_r;

endmodule

// File: tb/tb_andor_sweep_checker.sv
// Bench for andor_sweep_checker: gate models with stuck-at, random-flip and delayed
// faults, a sweep-level reference model compared every cycle, and pinned literal results.
module tb_andor_sweep_checker;

    localparam int S   = 2;
    localparam int PER = S + 2;
`ifdef STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic start_d = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- main DUT ----------------
    logic [9:0]  pv;
    logic [1:0]  gate_out;
    logic        busy, done, pass, first_err_vld;
    logic [10:0] err_cnt;
    logic [9:0]  first_err_vec;

    andor_sweep_checker #(.SETTLE_CYCLES(S), .ERR_CNT_W(11)) u_dut (
        .clk(clk), .resetn(resetn), .start(start),
        .p1a(pv[4]), .p1b(pv[5]), .p1c(pv[6]), .p1d(pv[7]), .p1e(pv[8]), .p1f(pv[9]),
        .p2a(pv[0]), .p2b(pv[1]), .p2c(pv[2]), .p2d(pv[3]),
        .p1y_i(gate_out[1]), .p2y_i(gate_out[0]),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_vld(first_err_vld)
    );

    // ---------------- delayed-gate DUTs (settle 1 and 3) ----------------
    logic [9:0]  pv1, pv3;
    logic [1:0]  d1_q [3] = '{default: 2'b00};
    logic [1:0]  d3_q [3] = '{default: 2'b00};
    logic        busy1, done1, pass1, fvld1, busy3, done3, pass3, fvld3;
    logic [10:0] err1, err3;
    logic [9:0]  fev1, fev3;

    andor_sweep_checker #(.SETTLE_CYCLES(1), .ERR_CNT_W(11)) u_dut_s1 (
        .clk(clk), .resetn(resetn), .start(start_d),
        .p1a(pv1[4]), .p1b(pv1[5]), .p1c(pv1[6]), .p1d(pv1[7]), .p1e(pv1[8]), .p1f(pv1[9]),
        .p2a(pv1[0]), .p2b(pv1[1]), .p2c(pv1[2]), .p2d(pv1[3]),
        .p1y_i(d1_q[2][1]), .p2y_i(d1_q[2][0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_vec(fev1), .first_err_vld(fvld1)
    );

    andor_sweep_checker #(.SETTLE_CYCLES(3), .ERR_CNT_W(11)) u_dut_s3 (
        .clk(clk), .resetn(resetn), .start(start_d),
        .p1a(pv3[4]), .p1b(pv3[5]), .p1c(pv3[6]), .p1d(pv3[7]), .p1e(pv3[8]), .p1f(pv3[9]),
        .p2a(pv3[0]), .p2b(pv3[1]), .p2c(pv3[2]), .p2d(pv3[3]),
        .p1y_i(d3_q[2][1]), .p2y_i(d3_q[2][0]),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .first_err_vec(fev3), .first_err_vld(fvld3)
    );

    // ---------------- gate behaviour ----------------
    function automatic logic [1:0] gold(input logic [9:0] v);
        logic s1, s2;
        s1 = (v[6:4] == 3'b111) || (v[9:7] == 3'b111);
        s2 = (v[1:0] == 2'b11) || (v[3:2] == 2'b11);
        return {s1, s2};
    endfunction

    // mode 0 correct, 1 p2y stuck-at-0, 2 p1y stuck-at-1, 3 random output flips
    function automatic logic [1:0] gate_fn(input logic [9:0] v, input int md, input logic [1:0] flip);
        logic [1:0] g;
        g = gold(v);
        case (md)
            1: g[0] = 1'b0;
            2: g[1] = 1'b1;
            3: g = g ^ flip;
            default: g = g;
        endcase
        return g;
    endfunction

    int         mode = 0;
    logic [1:0] fl [1024];

    always_comb begin
        gate_out = 2'b00;
        gate_out = gate_fn(pv, mode, fl[pv]);
    end

    // Gate outputs become valid only in the third cycle after an input change
    always @(posedge clk) begin
        d1_q[0] <= gold(pv1);
        d1_q[1] <= d1_q[0];
        d1_q[2] <= d1_q[1];
        d3_q[0] <= gold(pv3);
        d3_q[1] <= d3_q[0];
        d3_q[2] <= d3_q[1];
    end

    // ---------------- reference model ----------------
    int pre [1025];     // pre[c] = mismatching vectors among 0..c-1
    int first_idx;      // lowest mismatching vector, 1024 if none

    task automatic prep(input int md);
        bit m;
        mode      = md;
        pre[0]    = 0;
        first_idx = 1024;
        for (int v = 0; v < 1024; v++) begin
            m = (gate_fn(10'(v), md, fl[v]) != gold(10'(v)));
            pre[v+1] = pre[v] + int'(m);
            if (m && first_idx == 1024) first_idx = v;
        end
    endtask

    function automatic bit fin(input int kk);
        int c;
        c = kk / PER;
        return (c >= 1024) || (STOP && first_idx < c);
    endfunction

    // m_phase: 0 idle, 1 sweeping (m_k edges since the accepting edge), 2 done cycle
    int m_phase = 0, m_k = 0, h_err = 0, h_fev = 0, h_vec = 0;
    bit m_ran = 1'b0, h_vld = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase <= 0; m_k <= 0; m_ran <= 1'b0;
            h_err <= 0; h_vld <= 1'b0; h_fev <= 0; h_vec <= 0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase <= 1; m_k <= 0; m_ran <= 1'b1; end
                1: begin
                    m_k <= m_k + 1;
                    if (fin(m_k + 1)) begin
                        m_phase <= 2;
                        h_err   <= pre[(m_k + 1) / PER];
                        h_vld   <= (first_idx < (m_k + 1) / PER);
                        h_fev   <= (first_idx < (m_k + 1) / PER) ? first_idx : 0;
                        h_vec   <= (m_k + 1) / PER - 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Every-cycle comparison of the main DUT against the model
    always @(negedge clk) begin
        int c, ev, ee, efev;
        bit eb, ed, evld, ep, bad;
        c = m_k / PER;
        if (m_phase == 1) begin
            eb = 1'b1; ed = 1'b0; ev = c; ee = pre[c];
            evld = (first_idx < c); efev = evld ? first_idx : 0; ep = 1'b0;
        end else begin
            eb = 1'b0; ed = (m_phase == 2); ev = h_vec; ee = h_err;
            evld = h_vld; efev = h_fev; ep = m_ran && (h_err == 0);
        end
        bad = (busy !== eb) || (done !== ed) || (int'(pv) != ev) || (int'(err_cnt) != ee) ||
              (first_err_vld !== evld) || (int'(first_err_vec) != efev) || (pass !== ep);
        n_tests++;
        if (bad) begin
            n_fail++;
            if (n_fail <= 20)
                $display("FAIL cycle_check t=%0t got/expected busy %0b/%0b done %0b/%0b vec %0d/%0d err %0d/%0d vld %0b/%0b fev %0d/%0d pass %0b/%0b",
                         $time, busy, eb, done, ed, pv, ev, err_cnt, ee, first_err_vld, evld,
                         first_err_vec, efev, pass, ep);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_sweep(input int md, input int repulse_at, output int ncyc);
        bit got;
        @(negedge clk);
        prep(md);
        start = 1'b1;
        ncyc  = 0;
        got   = 1'b0;
        while (ncyc < 6000 && !got) begin
            @(posedge clk);
            ncyc++;
            @(negedge clk);
            start = (ncyc == repulse_at);
            got   = done;
        end
        start = 1'b0;
        chk("sweep_done_seen", int'(got), 1);
    endtask

    function automatic int exp_len();
        return (STOP && first_idx < 1024) ? (first_idx + 1) * PER + 1 : 1024 * PER + 1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n, exp_e1, exp_f1, ndone;
        for (int v = 0; v < 1024; v++) fl[v] = 2'b00;
        prep(0);
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err_cnt), 0);
        chk("reset_vec", int'(pv), 0);
        resetn = 1'b1;

        // correct gate, plus a stray start mid-sweep that must be ignored
        run_sweep(0, 1000, n);
        chk("t1_len", n, 4097);
        chk("t1_pass", int'(pass), 1);
        chk("t1_err", int'(err_cnt), 0);
        chk("t1_vld", int'(first_err_vld), 0);

        // delayed gate: settle 1 samples stale outputs, settle 3 is clean
        exp_e1 = 0; exp_f1 = 1024;
        for (int v = 1; v < 1024; v++)
            if (gold(10'(v)) != gold(10'(v - 1))) begin
                exp_e1++;
                if (exp_f1 == 1024) exp_f1 = v;
            end
        if (STOP) exp_e1 = 1;
        @(negedge clk); start_d = 1'b1;
        @(negedge clk); start_d = 1'b0;
        n = 0;
        while (n < 6000 && !done3) begin @(negedge clk); n++; end
        chk("t4_s3_done_seen", int'(done3), 1);
        chk("t4_s1_pass", int'(pass1), 0);
        chk("t4_s1_err", int'(err1), exp_e1);
        chk("t4_s1_first", int'(fev1), exp_f1);
        chk("t4_s1_first_lit", int'(fev1), 3);
        chk("t4_s3_pass", int'(pass3), 1);
        chk("t4_s3_err", int'(err3), 0);

        // p2y stuck-at-0
        run_sweep(1, 0, n);
        chk("t2_len", n, STOP ? 17 : 4097);
        chk("t2_err", int'(err_cnt), STOP ? 1 : 448);
        chk("t2_first", int'(first_err_vec), 3);
        chk("t2_pass", int'(pass), 0);
        chk("t2_vec_held", int'(pv), STOP ? 3 : 1023);

        // p1y stuck-at-1
        run_sweep(2, 0, n);
        chk("t3_err", int'(err_cnt), STOP ? 1 : 784);
        chk("t3_first", int'(first_err_vec), 0);
        chk("t3_pass", int'(pass), 0);

        // random output flips
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 1024; v++)
                fl[v] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_sweep(3, 0, n);
            chk("rand_len", n, exp_len());
            chk("rand_err", int'(err_cnt), STOP ? int'(first_idx < 1024) : pre[1024]);
        end

        // reset while sweeping vector 500
        @(negedge clk); prep(0); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (500 * PER) @(posedge clk);
        #1;
        chk("t5_vec500", int'(pv), 500);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_vec", int'(pv), 0);
        chk("t5_abort_err", int'(err_cnt), 0);
        @(negedge clk); resetn = 1'b1;
        ndone = 0;
        repeat (20) begin @(negedge clk); ndone += int'(done); end
        chk("t5_no_done", ndone, 0);

        // sweep completes normally after the abort
        run_sweep(0, 0, n);
        chk("t5_recover_len", n, 4097);
        chk("t5_recover_pass", int'(pass), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
